ifetch_unit: RTL and testbench

Instruction fetch front end for the LC-3b datapath. It is the producer that feeds the instruction register: it holds the PC, issues word reads to instruction memory using the mem_read/mem_resp handshake, and buffers one fetched word. It offers that word to the IR/control side with a valid/ready handshake and accepts PC redirects from branch, JMP, JSR and TRAP logic.

---
 rtl/lc3b_types.sv | 15 +
 rtl/ifetch_pc.sv | 41 ++++
 rtl/ifetch_unit.sv | 102 ++++++++++
 tb/tb_ifetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, extended with the instruction fetch state and
// the fetch PC stride.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } lc3b_fetch_state;

  localparam lc3b_word lc3b_pc_inc = 16'd2;

endpackage

// File: rtl/ifetch_pc.sv
// Fetch program counter: synchronous active-low reset, redirect load with the
// byte bit cleared, and a fixed-stride increment (load wins over increment).
module ifetch_pc
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word PC_INC   = lc3b_pc_inc
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_i,
  input  lc3b_word target_i,
  input  logic     inc_i,
  output lc3b_word pc_o,
  output lc3b_word pc_d_o
);

  lc3b_word pc_q;
  lc3b_word pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = {target_i[15:1], 1'b0};
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o   = pc_q;
  assign pc_d_o = pc_d;

endmodule

// File: rtl/ifetch_unit.sv
// LC-3b instruction fetch front end: issues word reads, buffers one fetched
// word for the IR side, and follows PC redirects without aborting a read.
module ifetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word PC_INC   = lc3b_pc_inc
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fetch_enable,
  output logic     mem_read,
  output lc3b_word mem_address,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  output logic     out_valid,
  input  logic     out_ready,
  output lc3b_word out_instr,
  output lc3b_word out_pc_next,
  input  logic     pc_load,
  input  lc3b_word pc_target
);

  lc3b_fetch_state state_q, state_d;
  logic            discard_q, discard_d;
  lc3b_word        instr_q, instr_d;
  lc3b_word        pc_next_q, pc_next_d;
  lc3b_word        addr_q, addr_d;
  lc3b_word        pc;
  lc3b_word        pc_d;
  logic            pc_inc;

  ifetch_pc #(
    .RESET_PC(RESET_PC),
    .PC_INC  (PC_INC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (pc_load),
    .target_i(pc_target),
    .inc_i   (pc_inc),
    .pc_o    (pc),
    .pc_d_o  (pc_d)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    pc_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_enable && !pc_load) state_d = REQ;
      end
      REQ: begin
        if (mem_resp) begin
          discard_d = 1'b0;
          // A redirect before or with the response turns this read into a refetch.
          if (!discard_q && !pc_load) begin
            instr_d   = mem_rdata;
            pc_next_d = pc + PC_INC;
            pc_inc    = 1'b1;
            state_d   = HOLD;
          end
        end else if (pc_load) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready || pc_load) state_d = fetch_enable ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bus address is frozen for the whole life of an outstanding read.
  assign addr_d = (state_q != REQ || mem_resp) ? pc_d : addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      instr_q   <= '0;
      pc_next_q <= '0;
      addr_q    <= RESET_PC;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      addr_q    <= addr_d;
    end
  end

  assign mem_read    = (state_q == REQ);
  assign mem_address = addr_q;
  assign out_valid   = (state_q == HOLD);
  assign out_instr   = instr_q;
  assign out_pc_next = pc_next_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level fetch model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_enable;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc_next;
  logic        pc_load;
  logic [15:0] pc_target;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, outstanding read, buffered word.
  logic [15:0] m_pc;
  logic        m_pend;
  logic        m_stale;
  logic [15:0] m_req_addr;
  logic        m_word;
  logic [15:0] m_instr;
  logic [15:0] m_pcn;
  logic        m_exp_rd;

  ifetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_enable(fetch_enable),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc_next (out_pc_next),
    .pc_load     (pc_load),
    .pc_target   (pc_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 16'h0000;
    m_pend   = 1'b0;
    m_stale  = 1'b0;
    m_req_addr = 16'h0000;
    m_word   = 1'b0;
    m_instr  = 16'h0000;
    m_pcn    = 16'h0000;
    m_exp_rd = 1'b0;
  endtask

  // Check current outputs, advance the model with the current inputs, clock.
  task automatic cycle();
    logic nxt_rd;
    chk("mem_read", {15'b0, mem_read}, {15'b0, m_exp_rd});
    chk("out_valid", {15'b0, out_valid}, {15'b0, m_word});
    if (m_word) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_pc_next", out_pc_next, m_pcn);
    end
    if (m_exp_rd) begin
      if (!m_pend) begin
        m_pend     = 1'b1;
        m_stale    = 1'b0;
        m_req_addr = m_pc;
        chk("req_addr", mem_address, m_pc);
      end else begin
        chk("addr_stable", mem_address, m_req_addr);
      end
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      nxt_rd = 1'b0;
      if (m_pend && !mem_resp) begin
        nxt_rd = 1'b1;
      end else if (m_pend) begin
        m_pend = 1'b0;
        if (m_stale || pc_load) begin
          nxt_rd = 1'b1;
        end else begin
          m_word  = 1'b1;
          m_instr = mem_rdata;
          m_pcn   = m_req_addr + 16'd2;
          m_pc    = m_req_addr + 16'd2;
        end
      end else if (m_word) begin
        if (out_ready || pc_load) begin
          m_word = 1'b0;
          nxt_rd = fetch_enable;
        end
      end else begin
        nxt_rd = fetch_enable && !pc_load;
      end
      if (pc_load) begin
        m_pc = pc_target & 16'hFFFE;
        if (m_pend) m_stale = 1'b1;
      end
      m_exp_rd = nxt_rd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    fetch_enable = 1'b0;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    out_ready    = 1'b0;
    pc_load      = 1'b0;
    pc_target    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    chk("rst_mem_read", {15'b0, mem_read}, 16'h0000);
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    chk("rst_out_instr", out_instr, 16'h0000);
    chk("rst_out_pc_next", out_pc_next, 16'h0000);

    // Basic fetch
    rst_n = 1'b1;
    fetch_enable = 1'b1;
    cycle();
    chk("basic_addr", mem_address, 16'h0000);
    cycle();
    cycle();
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    cycle();
    mem_resp = 1'b0;
    chk("basic_valid", {15'b0, out_valid}, 16'h0001);
    chk("basic_instr", out_instr, 16'h1234);
    chk("basic_pc_next", out_pc_next, 16'h0002);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {15'b0, out_valid}, 16'h0001);
      chk("bp_instr", out_instr, 16'h1234);
      chk("bp_no_read", {15'b0, mem_read}, 16'h0000);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("bp_next_read", {15'b0, mem_read}, 16'h0001);
    chk("bp_next_addr", mem_address, 16'h0002);
    mem_resp = 1'b1; mem_rdata = 16'h5555;
    cycle();
    mem_resp = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("seq_addr", mem_address, 16'h0004);

    // Redirect mid-read
    pc_load = 1'b1; pc_target = 16'h3001;
    cycle();
    pc_load = 1'b0;
    chk("redir_addr_held", mem_address, 16'h0004);
    cycle();
    mem_resp = 1'b1; mem_rdata = 16'hAAAA;
    cycle();
    mem_resp = 1'b0;
    chk("redir_dropped", {15'b0, out_valid}, 16'h0000);
    chk("redir_read", {15'b0, mem_read}, 16'h0001);
    chk("redir_addr", mem_address, 16'h3000);
    mem_resp = 1'b1; mem_rdata = 16'h0BEE;
    cycle();
    mem_resp = 1'b0;
    chk("redir_instr", out_instr, 16'h0BEE);
    chk("redir_pc_next", out_pc_next, 16'h3002);

    // Redirect in HOLD
    pc_load = 1'b1; pc_target = 16'h0100;
    cycle();
    pc_load = 1'b0;
    chk("hold_redir_valid", {15'b0, out_valid}, 16'h0000);
    chk("hold_redir_read", {15'b0, mem_read}, 16'h0001);
    chk("hold_redir_addr", mem_address, 16'h0100);

    // Wrap
    mem_resp = 1'b1; mem_rdata = 16'h1111;
    cycle();
    mem_resp = 1'b0;
    pc_load = 1'b1; pc_target = 16'hFFFE; out_ready = 1'b1;
    cycle();
    pc_load = 1'b0; out_ready = 1'b0;
    chk("wrap_req_addr", mem_address, 16'hFFFE);
    mem_resp = 1'b1; mem_rdata = 16'h2222;
    cycle();
    mem_resp = 1'b0;
    chk("wrap_pc_next", out_pc_next, 16'h0000);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("wrap_next_addr", mem_address, 16'h0000);

    // Reset mid-read, then a late response
    fetch_enable = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_mid_read", {15'b0, mem_read}, 16'h0000);
    chk("rst_mid_valid", {15'b0, out_valid}, 16'h0000);
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    cycle();
    mem_resp = 1'b0;
    chk("late_resp_valid", {15'b0, out_valid}, 16'h0000);
    cycle();

    // Redirect while idle holds off the fetch for that cycle
    fetch_enable = 1'b1;
    pc_load = 1'b1; pc_target = 16'h0041;
    cycle();
    pc_load = 1'b0;
    cycle();
    chk("idle_redir_addr", mem_address, 16'h0040);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      fetch_enable = ($urandom_range(0, 9) < 8);
      out_ready    = $urandom_range(0, 1) == 1;
      pc_load      = ($urandom_range(0, 9) == 0);
      pc_target    = 16'($urandom);
      mem_rdata    = 16'($urandom);
      if (m_exp_rd) mem_resp = ($urandom_range(0, 9) < 4);
      else          mem_resp = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
